// File: rtl/cnn_pkg.sv
// Shared types and geometry helpers for the streaming convolution engine.
package cnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_MAC,
        ST_OUT,
        ST_DRAIN,
        ST_FIN
    } conv_state_e;

    typedef enum logic {
        STRIDE_1 = 1'b0,
        STRIDE_2 = 1'b1
    } conv_stride_e;

    // Number of valid-mode output positions along one axis.
    function automatic int unsigned out_dim(input int unsigned w, input int unsigned k,
                                            input int unsigned s);
        return (w - k) / s + 1;
    endfunction

    // Bits needed to index 0..n-1 (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate: unsigned pixel times signed coefficient, wrapping accumulator.
module conv_mac #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic [DATA_W-1:0]        i_pix,
    input  logic signed [COEF_W-1:0] i_coef,
    output logic signed [ACC_W-1:0]  o_acc_nxt
);
    localparam int PW = DATA_W + COEF_W + 1;

    logic signed [PW-1:0]    w_pix_s;
    logic signed [PW-1:0]    w_coef_s;
    logic signed [PW-1:0]    w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] r_acc;

    assign w_pix_s    = {{(PW - DATA_W){1'b0}}, i_pix};
    assign w_coef_s   = {{(PW - COEF_W){i_coef[COEF_W-1]}}, i_coef};
    assign w_prod     = w_pix_s * w_coef_s;
    assign w_prod_ext = {{(ACC_W - PW){w_prod[PW-1]}}, w_prod};
    assign o_acc_nxt  = r_acc + w_prod_ext;

    // Accumulator: clear has priority over accumulate.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_acc_nxt;
        end
    end

endmodule

// File: rtl/cnn_conv_stream.sv
// Streaming valid-mode KxK convolution with K-row circular line buffer, stride 1/2, optional ReLU.
module cnn_conv_stream
    import cnn_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stride2,
    input  logic                     relu_en,
    input  logic                     kern_wr_en,
    input  logic [$clog2(K*K)-1:0]   kern_wr_addr,
    input  logic signed [COEF_W-1:0] kern_wr_data,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic [DATA_W-1:0]        pix_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);
    localparam int unsigned NTAP = K * K;
    localparam int unsigned CW   = idx_w(IMG_W);
    localparam int unsigned RW   = idx_w(IMG_H + 1);
    localparam int unsigned SW   = idx_w(K);
    localparam int unsigned SW1  = SW + 1;
    localparam int unsigned TW   = $clog2(NTAP);
    localparam logic [CW-1:0] LAST_C1 = CW'(IMG_W - K);
    localparam logic [CW-1:0] LAST_C2 = CW'((out_dim(IMG_W, K, 2) - 1) * 2);
    localparam logic [RW-1:0] LAST_R1 = RW'(IMG_H - K);
    localparam logic [RW-1:0] LAST_R2 = RW'((out_dim(IMG_H, K, 2) - 1) * 2);

    conv_state_e              r_state, w_state_nxt;
    conv_stride_e             r_stride;
    logic                     r_relu;
    logic signed [COEF_W-1:0] r_kern [NTAP];
    logic [DATA_W-1:0]        r_lb [K][IMG_W];
    logic [RW-1:0]            r_in_row, r_row_base;
    logic [CW-1:0]            r_in_col, r_col_base, r_kc;
    logic [SW-1:0]            r_wr_slot, r_base_slot, r_kr;
    logic [TW-1:0]            r_tap;
    logic signed [ACC_W-1:0]  r_out_data;
    logic                     r_out_last;

    logic                     w_pix_hs, w_last_col, w_fill_done, w_drain_done, w_tap_last;
    logic                     w_row_end, w_frame_end, w_pix_left, w_acc_clr, w_mac_en;
    logic [1:0]               w_step;
    logic [CW-1:0]            w_last_c, w_rd_col;
    logic [RW-1:0]            w_last_r, w_need_row;
    logic [SW1-1:0]           w_rd_sum, w_bs_sum;
    logic [SW-1:0]            w_rd_slot, w_bs_nxt;
    logic signed [ACC_W-1:0]  w_acc_nxt;

    assign w_pix_hs     = pix_valid & pix_ready;
    assign w_last_col   = (r_in_col == CW'(IMG_W - 1));
    assign w_need_row   = r_row_base + RW'(K - 1);
    assign w_fill_done  = w_pix_hs & w_last_col & (r_in_row == w_need_row);
    assign w_drain_done = w_pix_hs & w_last_col & (r_in_row == RW'(IMG_H - 1));
    assign w_tap_last   = (r_tap == TW'(NTAP - 1));
    assign w_step       = (r_stride == STRIDE_2) ? 2'd2 : 2'd1;
    assign w_last_c     = (r_stride == STRIDE_2) ? LAST_C2 : LAST_C1;
    assign w_last_r     = (r_stride == STRIDE_2) ? LAST_R2 : LAST_R1;
    assign w_row_end    = (r_col_base == w_last_c);
    assign w_frame_end  = w_row_end & (r_row_base == w_last_r);
    assign w_pix_left   = (r_in_row != RW'(IMG_H));

    // Window row r lives in slot (base_slot + r) mod K; the wrap needs at most one subtract.
    assign w_rd_sum  = {1'b0, r_base_slot} + {1'b0, r_kr};
    assign w_rd_slot = (w_rd_sum >= SW1'(K)) ? SW'(w_rd_sum - SW1'(K)) : SW'(w_rd_sum);
    assign w_bs_sum  = {1'b0, r_base_slot} + SW1'(w_step);
    assign w_bs_nxt  = (w_bs_sum >= SW1'(K)) ? SW'(w_bs_sum - SW1'(K)) : SW'(w_bs_sum);
    assign w_rd_col  = r_col_base + r_kc;

    assign out_data = r_out_data;
    assign out_last = r_out_last;

    conv_mac #(
        .DATA_W(DATA_W),
        .COEF_W(COEF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_clr    (w_acc_clr),
        .i_en     (w_mac_en),
        .i_pix    (r_lb[w_rd_slot][w_rd_col]),
        .i_coef   (r_kern[r_tap]),
        .o_acc_nxt(w_acc_nxt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and handshake/status outputs.
    always_comb begin
        w_state_nxt = r_state;
        pix_ready   = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        w_acc_clr   = 1'b0;
        w_mac_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = ST_FILL;
            end
            ST_FILL: begin
                pix_ready = 1'b1;
                if (w_fill_done) begin
                    w_acc_clr   = 1'b1;
                    w_state_nxt = ST_MAC;
                end
            end
            ST_MAC: begin
                w_mac_en = 1'b1;
                if (w_tap_last) w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (!w_row_end) begin
                        w_acc_clr   = 1'b1;
                        w_state_nxt = ST_MAC;
                    end else if (!w_frame_end) begin
                        w_state_nxt = ST_FILL;
                    end else if (w_pix_left) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_FIN;
                    end
                end
            end
            ST_DRAIN: begin
                pix_ready = 1'b1;
                if (w_drain_done) w_state_nxt = ST_FIN;
            end
            ST_FIN: begin
                busy        = 1'b0;
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Kernel register file: writable only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NTAP; i++) r_kern[i] <= '0;
        end else if (r_state == ST_IDLE && kern_wr_en && ({1'b0, kern_wr_addr} < (TW + 1)'(NTAP))) begin
            r_kern[kern_wr_addr] <= kern_wr_data;
        end
    end

    // Line buffer: every slot read in a frame is written earlier in that frame, so no reset.
    always_ff @(posedge clk) begin
        if (r_state == ST_FILL && w_pix_hs) r_lb[r_wr_slot][r_in_col] <= pix_data;
    end

    // Frame config, stream pointers, window position, tap counters and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stride    <= STRIDE_1;
            r_relu      <= 1'b0;
            r_in_row    <= '0;
            r_in_col    <= '0;
            r_wr_slot   <= '0;
            r_row_base  <= '0;
            r_col_base  <= '0;
            r_base_slot <= '0;
            r_tap       <= '0;
            r_kr        <= '0;
            r_kc        <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_stride    <= conv_stride_e'(stride2);
                        r_relu      <= relu_en;
                        r_in_row    <= '0;
                        r_in_col    <= '0;
                        r_wr_slot   <= '0;
                        r_row_base  <= '0;
                        r_col_base  <= '0;
                        r_base_slot <= '0;
                        r_tap       <= '0;
                        r_kr        <= '0;
                        r_kc        <= '0;
                    end
                end
                ST_FILL, ST_DRAIN: begin
                    if (w_pix_hs) begin
                        if (w_last_col) begin
                            r_in_col  <= '0;
                            r_in_row  <= r_in_row + RW'(1);
                            r_wr_slot <= (r_wr_slot == SW'(K - 1)) ? '0 : r_wr_slot + SW'(1);
                        end else begin
                            r_in_col <= r_in_col + CW'(1);
                        end
                    end
                end
                ST_MAC: begin
                    if (w_tap_last) begin
                        r_tap      <= '0;
                        r_kr       <= '0;
                        r_kc       <= '0;
                        r_out_data <= (r_relu && w_acc_nxt[ACC_W-1]) ? '0 : w_acc_nxt;
                        r_out_last <= w_frame_end;
                    end else begin
                        r_tap <= r_tap + TW'(1);
                        if (r_kc == CW'(K - 1)) begin
                            r_kc <= '0;
                            r_kr <= r_kr + SW'(1);
                        end else begin
                            r_kc <= r_kc + CW'(1);
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_out_data <= '0;
                        r_out_last <= 1'b0;
                        if (!w_row_end) begin
                            r_col_base <= r_col_base + CW'(w_step);
                        end else begin
                            r_col_base  <= '0;
                            r_row_base  <= r_row_base + RW'(w_step);
                            r_base_slot <= w_bs_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_conv_stream.sv
`timescale 1ns/1ps
module tb_cnn_conv_stream;
    localparam int W = 8, H = 8, K = 3, NT = K * K, LIMIT = 6000;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0, stride2 = 1'b0, relu_en = 1'b0;
    logic               kern_wr_en = 1'b0;
    logic [3:0]         kern_wr_addr = '0;
    logic signed [7:0]  kern_wr_data = '0;
    logic               pix_valid = 1'b0, pix_ready;
    logic [7:0]         pix_data = '0;
    logic               out_valid, out_ready = 1'b0;
    logic signed [31:0] out_data;
    logic               out_last, busy, done;

    int checks = 0, failures = 0;
    int img [H][W];
    int kmod [NT];
    int exp_q [$];
    int got_q [$];
    int pix_cnt = 0, done_cnt = 0, rcv_cnt = 0;
    bit hold_pend = 0;
    logic signed [31:0] hold_data;
    logic hold_last;
    bit frame_end = 0, aborted = 0;

    always #5 clk = ~clk;

    cnn_conv_stream #(
        .IMG_W(W), .IMG_H(H), .K(K), .DATA_W(8), .COEF_W(8), .ACC_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stride2(stride2), .relu_en(relu_en),
        .kern_wr_en(kern_wr_en), .kern_wr_addr(kern_wr_addr), .kern_wr_data(kern_wr_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: direct valid-mode convolution over the whole image.
    function automatic void build_expected(input int s, input bit relu);
        int ow, oh, acc;
        ow = (W - K) / s + 1;
        oh = (H - K) / s + 1;
        exp_q.delete();
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++) begin
                acc = 0;
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        acc += img[oy*s+r][ox*s+c] * kmod[r*K+c];
                if (relu && acc < 0) acc = 0;
                exp_q.push_back(acc);
            end
    endfunction

    // Single compare process: every accepted result against the model, plus hold-while-stalled.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_pend = 0;
            end else begin
                if (pix_valid && pix_ready) pix_cnt++;
                if (done) done_cnt++;
                if (hold_pend) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, hold_data);
                    chk("stall_last", out_last, hold_last);
                end
                hold_pend = out_valid && !out_ready;
                hold_data = out_data;
                hold_last = out_last;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_result: got %0d expected no result", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("result_data[%0d]", rcv_cnt), out_data, e);
                        chk($sformatf("result_last[%0d]", rcv_cnt), out_last, exp_q.size() == 0);
                    end
                    got_q.push_back(out_data);
                    rcv_cnt++;
                end
            end
        end
    end

    task automatic load_kernel();
        for (int i = 0; i < NT; i++) begin
            kern_wr_en   = 1'b1;
            kern_wr_addr = 4'(i);
            kern_wr_data = 8'(kmod[i]);
            tick();
        end
        kern_wr_en = 1'b0;
    endtask

    // 0: edge rows -1/0/+1, 1: all ones, 2: all -128, other: random
    task automatic set_kernel(input int mode);
        for (int i = 0; i < NT; i++)
            case (mode)
                0:       kmod[i] = (i / K == 0) ? -1 : (i / K == K - 1) ? 1 : 0;
                1:       kmod[i] = 1;
                2:       kmod[i] = -128;
                default: kmod[i] = int'($urandom_range(0, 255)) - 128;
            endcase
        load_kernel();
    endtask

    // 0: row*10, 1: (7-row)*10, 2: col, 3: 255, other: random
    task automatic set_img(input int mode);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (mode)
                    0:       img[r][c] = r * 10;
                    1:       img[r][c] = (H - 1 - r) * 10;
                    2:       img[r][c] = c;
                    3:       img[r][c] = 255;
                    default: img[r][c] = int'($urandom_range(0, 255));
                endcase
    endtask

    task automatic pin(input string name, input int idx, input int exp);
        if (got_q.size() > idx) chk(name, got_q[idx], exp);
        else chk({name, "_missing"}, got_q.size(), idx + 1);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_pix_ready"}, pix_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
    endtask

    // stall: 0 always ready, 1 five cycles low per result, 2 random
    task automatic run_frame(input bit s2, input bit relu, input bit gaps, input int stall,
                             input bit noise, input int abort_at);
        build_expected(s2 ? 2 : 1, relu);
        got_q.delete();
        pix_cnt = 0; done_cnt = 0; rcv_cnt = 0; frame_end = 0; aborted = 0;
        stride2 = s2; relu_en = relu; start = 1'b1;
        tick();
        start = 1'b0; stride2 = 1'b0; relu_en = 1'b0;
        chk("busy_after_start", busy, 1);
        fork
            begin : producer
                int idx;
                bit hs;
                idx = 0;
                while (idx < W * H && !frame_end) begin
                    pix_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                    pix_data  = 8'(img[idx / W][idx % W]);
                    @(negedge clk);
                    hs = pix_valid && pix_ready;
                    tick();
                    if (hs) idx++;
                end
                pix_valid = 1'b0;
            end
            begin : consumer
                int sc;
                sc = 0;
                while (!frame_end) begin
                    out_ready = (stall == 0) ? 1'b1 : (stall == 1) ? (sc >= 5) : 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (out_valid) sc = out_ready ? 0 : sc + 1;
                    tick();
                end
                out_ready = 1'b0;
            end
            begin : disturber
                if (noise) begin
                    repeat (6) tick();
                    kern_wr_en = 1'b1; kern_wr_addr = 4'd0; kern_wr_data = 8'sd5; start = 1'b1;
                    repeat (4) tick();
                    kern_wr_en = 1'b0; start = 1'b0;
                end
            end
            begin : waiter
                bit fin;
                fin = 0;
                for (int c = 0; c < LIMIT && !fin; c++) begin
                    @(negedge clk);
                    if (done) begin
                        fin = 1;
                    end else if (abort_at != 0 && rcv_cnt >= abort_at) begin
                        @(posedge clk);
                        #3;
                        rst_n = 1'b0;
                        #1;
                        check_quiet("abort_rst");
                        exp_q.delete();
                        aborted = 1;
                        fin = 1;
                    end
                end
                if (!fin) chk("frame_timeout", 0, 1);
                frame_end = 1;
            end
        join
        pix_valid = 1'b0;
        out_ready = 1'b0;
        if (!aborted) begin
            repeat (2) tick();
            chk("done_pulses", done_cnt, 1);
            chk("pixels_consumed", pix_cnt, W * H);
            chk("results_left", exp_q.size(), 0);
            chk("busy_after_done", busy, 0);
        end
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NT; i++) kmod[i] = 0;
        repeat (3) tick();
        check_quiet("reset");
        rst_n = 1'b1;
        tick();
        check_quiet("post_reset");

        // T1
        set_kernel(0); set_img(0);
        run_frame(0, 0, 0, 0, 0, 0);
        chk("t1_count", got_q.size(), 36);
        pin("t1_first", 0, 60);
        pin("t1_last", 35, 60);

        // T2
        set_img(1);
        run_frame(0, 0, 0, 0, 0, 0);
        pin("t2_neg", 0, -60);
        pin("t2_neg_last", 35, -60);
        run_frame(0, 1, 0, 0, 0, 0);
        pin("t2_relu", 7, 0);

        // T3
        set_kernel(1); set_img(2);
        run_frame(1, 0, 0, 0, 0, 0);
        chk("t3_count", got_q.size(), 9);
        pin("t3_r0", 0, 9);
        pin("t3_r1", 4, 27);
        pin("t3_r2", 8, 45);

        // T4
        set_kernel(0); set_img(0);
        run_frame(0, 0, 1, 1, 0, 0);
        chk("t4_count", got_q.size(), 36);
        pin("t4_mid", 17, 60);

        // T5: abort, then kernel must read back as zero, then reload
        run_frame(0, 0, 0, 0, 0, 20);
        chk("t5_results_before_abort", got_q.size(), 20);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_quiet("t5_after_rst");
        for (int i = 0; i < NT; i++) kmod[i] = 0;
        run_frame(0, 0, 0, 0, 0, 0);
        pin("t5_zero_kernel", 10, 0);
        set_kernel(0);
        run_frame(0, 0, 0, 0, 0, 0);
        chk("t5_count", got_q.size(), 36);
        pin("t5_last", 35, 60);

        // T6
        set_kernel(2); set_img(3);
        run_frame(0, 0, 0, 0, 1, 0);
        pin("t6_first", 0, -293760);
        pin("t6_last", 35, -293760);
        run_frame(1, 0, 0, 0, 0, 0);
        pin("t6_kernel_kept", 0, -293760);

        // randomized frames
        for (int n = 0; n < 4; n++) begin
            set_kernel(9); set_img(9);
            run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 2, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
